// File: rtl/cpu_pkg.sv
// Shared RV32I definitions for the decode stage: ALU op codes, opcode and
// funct constants, the decoded-control struct and the instruction decoder.
// Optional feature macro: DECODE_ILLEGAL_EN (adds the illegal flag to the
// ID/EX register struct).
package cpu_pkg;

  // ALU operation codes; bit 4 is reserved and always 0
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_SLL = 5'd5;
  localparam logic [4:0] ALU_SRL = 5'd6;
  localparam logic [4:0] ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_BEQ = 5'd8;
  localparam logic [4:0] ALU_BNE = 5'd9;
  localparam logic [4:0] ALU_BLT = 5'd10;
  localparam logic [4:0] ALU_BGE = 5'd11;
  localparam logic [4:0] ALU_LUI = 5'd12;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_JALR    = 3'b000;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // Control fields derived from one instruction word
  typedef struct packed {
    logic [4:0] alu_op;
    logic       src_a_pc;
    logic       src_b_imm;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       legal;
    logic       rs1_used;
    logic       rs2_used;
  } decode_t;

  // Contents of the ID/EX register (the PC lives beside it, width is a parameter)
  typedef struct packed {
    logic        valid;
    logic [4:0]  alu_op;
    logic        src_a_pc;
    logic        src_b_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
`ifdef DECODE_ILLEGAL_EN
    logic        illegal;
`endif
  } ex_reg_t;

  // Decode one instruction; unsupported encodings collapse to an all-zero
  // record, i.e. op add with every enable and flag cleared.
  function automatic decode_t decode(input logic [31:0] instr);
    decode_t    d;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    d   = '0;
    case (opc)
      OP_R: begin
        d.legal    = 1'b1;
        d.reg_we   = 1'b1;
        d.rs1_used = 1'b1;
        d.rs2_used = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD_SUB: d.alu_op = ALU_ADD;
            F3_SLL:     d.alu_op = ALU_SLL;
            F3_XOR:     d.alu_op = ALU_XOR;
            F3_SRL_SRA: d.alu_op = ALU_SRL;
            F3_OR:      d.alu_op = ALU_OR;
            F3_AND:     d.alu_op = ALU_AND;
            default:    d.legal  = 1'b0;
          endcase
        end else if (f7 == F7_ALT) begin
          case (f3)
            F3_ADD_SUB: d.alu_op = ALU_SUB;
            F3_SRL_SRA: d.alu_op = ALU_SRA;
            default:    d.legal  = 1'b0;
          endcase
        end else begin
          d.legal = 1'b0;
        end
      end
      OP_I: begin
        d.legal     = 1'b1;
        d.reg_we    = 1'b1;
        d.src_b_imm = 1'b1;
        d.rs1_used  = 1'b1;
        case (f3)
          F3_ADD_SUB: d.alu_op = ALU_ADD;
          F3_XOR:     d.alu_op = ALU_XOR;
          F3_OR:      d.alu_op = ALU_OR;
          F3_AND:     d.alu_op = ALU_AND;
          F3_SLL: begin
            d.alu_op = ALU_SLL;
            d.legal  = (f7 == F7_BASE);
          end
          F3_SRL_SRA: begin
            if (f7 == F7_BASE)     d.alu_op = ALU_SRL;
            else if (f7 == F7_ALT) d.alu_op = ALU_SRA;
            else                   d.legal  = 1'b0;
          end
          default: d.legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        d.legal     = (f3 == F3_LW);
        d.src_b_imm = 1'b1;
        d.mem_re    = 1'b1;
        d.reg_we    = 1'b1;
        d.rs1_used  = 1'b1;
      end
      OP_STORE: begin
        d.legal     = (f3 == F3_SW);
        d.src_b_imm = 1'b1;
        d.mem_we    = 1'b1;
        d.rs1_used  = 1'b1;
        d.rs2_used  = 1'b1;
      end
      OP_BRANCH: begin
        d.legal     = 1'b1;
        d.is_branch = 1'b1;
        d.rs1_used  = 1'b1;
        d.rs2_used  = 1'b1;
        case (f3)
          F3_BEQ:  d.alu_op = ALU_BEQ;
          F3_BNE:  d.alu_op = ALU_BNE;
          F3_BLT:  d.alu_op = ALU_BLT;
          F3_BGE:  d.alu_op = ALU_BGE;
          default: d.legal  = 1'b0;
        endcase
      end
      OP_JAL: begin
        d.legal     = 1'b1;
        d.src_a_pc  = 1'b1;
        d.src_b_imm = 1'b1;
        d.reg_we    = 1'b1;
        d.is_jal    = 1'b1;
      end
      OP_JALR: begin
        d.legal     = (f3 == F3_JALR);
        d.src_b_imm = 1'b1;
        d.reg_we    = 1'b1;
        d.is_jalr   = 1'b1;
        d.rs1_used  = 1'b1;
      end
      OP_LUI: begin
        d.legal     = 1'b1;
        d.alu_op    = ALU_LUI;
        d.src_b_imm = 1'b1;
        d.reg_we    = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    if (!d.legal) d = '0;
    return d;
  endfunction

endpackage

// File: rtl/id_ex_decode_stage_if.sv
// ID/EX output bundle carried from the decode stage to EX.
// master = decode stage (drives), slave = EX stage (consumes).
// Optional feature macro: DECODE_ILLEGAL_EN (adds ex_illegal).
// Handshake: there is no ready; ex_valid qualifies every other field in the
// same cycle, and back-pressure travels separately on stall.
interface id_ex_decode_stage_if #(
  parameter int PC_W = 32
);
  logic            ex_valid;
  logic [4:0]      ex_alu_op;
  logic            ex_src_a_pc;
  logic            ex_src_b_imm;
  logic [31:0]     ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic            ex_reg_we;
  logic            ex_mem_re;
  logic            ex_mem_we;
  logic            ex_is_branch;
  logic            ex_is_jal;
  logic            ex_is_jalr;
  logic [PC_W-1:0] ex_pc;
`ifdef DECODE_ILLEGAL_EN
  logic            ex_illegal;
`endif

  modport master (
    output ex_valid, ex_alu_op, ex_src_a_pc, ex_src_b_imm, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we,
           ex_is_branch, ex_is_jal, ex_is_jalr, ex_pc
`ifdef DECODE_ILLEGAL_EN
    , ex_illegal
`endif
  );

  modport slave (
    input ex_valid, ex_alu_op, ex_src_a_pc, ex_src_b_imm, ex_imm,
          ex_rs1, ex_rs2, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we,
          ex_is_branch, ex_is_jal, ex_is_jalr, ex_pc
`ifdef DECODE_ILLEGAL_EN
    , ex_illegal
`endif
  );
endinterface

// File: rtl/id_imm_gen.sv
// Combinational immediate generator: picks the I/S/B/J format or the raw
// U field from the opcode. Shift-immediates yield the zero-extended shamt so
// the funct7 bits of srai do not leak into the operand.
module id_imm_gen
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  logic [6:0] opc;
  logic [2:0] f3;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];

  // Format select; lui keeps instr[31:12] unshifted, the ALU shifts it
  always_comb begin
    imm = '0;
    case (opc)
      OP_I: begin
        if (f3 == F3_SLL || f3 == F3_SRL_SRA) imm = {27'b0, instr[24:20]};
        else                                  imm = {{20{instr[31]}}, instr[31:20]};
      end
      OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:         imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:        imm = {{19{instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
      OP_JAL:           imm = {{11{instr[31]}}, instr[31], instr[19:12],
                               instr[20], instr[30:21], 1'b0};
      OP_LUI:           imm = {12'b0, instr[31:12]};
      default:          imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_decode_stage.sv
// RV32I decode stage plus ID/EX pipeline register, with load-use hazard
// detection against the instruction currently held in EX.
// Optional feature macro: DECODE_ILLEGAL_EN (registers ex_illegal for
// unsupported encodings; without it they silently become NOPs).
// Register update priority: rst > flush > stall > hazard_stall > capture.
module id_ex_decode_stage
  import cpu_pkg::*;
#(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  input  logic [PC_W-1:0]        if_pc,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   hazard_stall,
  id_ex_decode_stage_if.master   ex
);

  localparam decode_t NOP_DEC = decode(NOP_INSTR);

  decode_t         dec;
  logic [31:0]     if_imm;
  logic [31:0]     nop_imm;
  logic [4:0]      if_rs1;
  logic [4:0]      if_rs2;
  logic [4:0]      if_rd;
  logic            gate;
  ex_reg_t         cap_d;
  ex_reg_t         bub_d;
  ex_reg_t         ex_q;
  logic [PC_W-1:0] pc_q;

  assign if_rs1 = if_instr[19:15];
  assign if_rs2 = if_instr[24:20];
  assign if_rd  = if_instr[11:7];

  id_imm_gen u_imm_if (
    .instr (if_instr),
    .imm   (if_imm)
  );

  id_imm_gen u_imm_nop (
    .instr (NOP_INSTR),
    .imm   (nop_imm)
  );

  // Decode the IF/ID instruction and build the capture and bubble records
  always_comb begin
    dec  = decode(if_instr);
    gate = if_valid & dec.legal;

    cap_d           = '0;
    cap_d.valid     = if_valid;
    cap_d.alu_op    = dec.alu_op;
    cap_d.src_a_pc  = dec.src_a_pc;
    cap_d.src_b_imm = dec.src_b_imm;
    cap_d.imm       = if_imm;
    cap_d.rs1       = if_rs1;
    cap_d.rs2       = if_rs2;
    cap_d.rd        = if_rd;
    cap_d.reg_we    = gate & dec.reg_we & (if_rd != 5'd0);
    cap_d.mem_re    = gate & dec.mem_re;
    cap_d.mem_we    = gate & dec.mem_we;
    cap_d.is_branch = gate & dec.is_branch;
    cap_d.is_jal    = gate & dec.is_jal;
    cap_d.is_jalr   = gate & dec.is_jalr;
`ifdef DECODE_ILLEGAL_EN
    cap_d.illegal   = if_valid & ~dec.legal;
`endif

    bub_d           = '0;
    bub_d.alu_op    = NOP_DEC.alu_op;
    bub_d.src_a_pc  = NOP_DEC.src_a_pc;
    bub_d.src_b_imm = NOP_DEC.src_b_imm;
    bub_d.imm       = nop_imm;
    bub_d.rs1       = NOP_INSTR[19:15];
    bub_d.rs2       = NOP_INSTR[24:20];
    bub_d.rd        = NOP_INSTR[11:7];
  end

  // Load-use: consumer in ID reads the register a load in EX will write
  assign hazard_stall = ex_q.valid & ex_q.mem_re & (ex_q.rd != 5'd0) & if_valid &
                        ((dec.legal & dec.rs1_used & (if_rs1 == ex_q.rd)) |
                         (dec.legal & dec.rs2_used & (if_rs2 == ex_q.rd))) &
                        ~stall & ~flush;

  // ID/EX register; a bubble clears the PC along with the enables
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
      pc_q <= '0;
    end else if (flush) begin
      ex_q <= bub_d;
      pc_q <= '0;
    end else if (!stall) begin
      if (hazard_stall) begin
        ex_q <= bub_d;
        pc_q <= '0;
      end else begin
        ex_q <= cap_d;
        pc_q <= if_pc;
      end
    end
  end

  assign ex.ex_valid     = ex_q.valid;
  assign ex.ex_alu_op    = ex_q.alu_op;
  assign ex.ex_src_a_pc  = ex_q.src_a_pc;
  assign ex.ex_src_b_imm = ex_q.src_b_imm;
  assign ex.ex_imm       = ex_q.imm;
  assign ex.ex_rs1       = ex_q.rs1;
  assign ex.ex_rs2       = ex_q.rs2;
  assign ex.ex_rd        = ex_q.rd;
  assign ex.ex_reg_we    = ex_q.reg_we;
  assign ex.ex_mem_re    = ex_q.mem_re;
  assign ex.ex_mem_we    = ex_q.mem_we;
  assign ex.ex_is_branch = ex_q.is_branch;
  assign ex.ex_is_jal    = ex_q.is_jal;
  assign ex.ex_is_jalr   = ex_q.is_jalr;
  assign ex.ex_pc        = pc_q;
`ifdef DECODE_ILLEGAL_EN
  assign ex.ex_illegal   = ex_q.illegal;
`endif

endmodule

// File: doc/id_ex_decode_stage.md
Name: id_ex_decode_stage

Overview:
- Decode stage plus ID/EX pipeline register for the 5-stage RV32I core.
- The other end of the ALU's op interface: produces the 5-bit ALU op code, operand selects and immediate consumed by EX.
- Also detects load-use hazards against the instruction currently in EX and inserts bubbles.

Parameters:
- PC_W, 32, width of the PC path.
- NOP_INSTR, 32'h00000013, instruction substituted on a bubble. Only its decoded fields appear; ex_valid is still 0.

Ports:
- clk  in  1  core clock; all state changes on its rising edge
- rst  in  1  synchronous reset, active-high
- if_valid  in  1  if_instr/if_pc hold a real instruction
- if_instr  in  32  instruction from IF/ID
- if_pc  in  PC_W  PC of if_instr
- stall  in  1  downstream stall; hold all ID/EX registers
- flush  in  1  branch/jump redirect; load a bubble
- hazard_stall  out  1  combinational; IF/ID must hold this cycle
- ex_valid  out  1  registered; EX holds a real instruction
- ex_alu_op  out  5  ALU op: add 0, sub 1, and 2, or 3, xor 4, sll 5, srl 6, sra 7, beq 8, bne 9, blt 10, bge 11, lui 12; bit 4 always 0
- ex_src_a_pc  out  1  ALU A = PC (jal) instead of rs1
- ex_src_b_imm  out  1  ALU B = ex_imm instead of rs2
- ex_imm  out  32  decoded immediate
- ex_rs1, ex_rs2, ex_rd  out  5 each  register indices
- ex_reg_we, ex_mem_re, ex_mem_we  out  1 each  writeback, load and store enables
- ex_is_branch, ex_is_jal, ex_is_jalr  out  1 each  control-flow class
- ex_pc  out  PC_W  registered if_pc

Behaviour:
- Reset: every registered output is 0, including ex_alu_op = 0 and ex_imm = 0. hazard_stall follows its equation from those zeroed registers.
- Latency: one cycle, instruction captured into ID/EX at the next edge.
- Register update priority: rst > flush (bubble) > stall (hold) > hazard_stall (bubble) > capture.
- Bubble: ex_valid = 0, all enables and class flags = 0, other fields decoded from NOP_INSTR.
- Capture: ex_valid = if_valid. When if_valid = 0, enables and flags are forced to 0.

Decode rules:
- R-type (funct7 0x00/0x20): add, sub, and, or, xor, sll, srl, sra.
- I-ALU: addi, andi, ori, xori, slli, srli, srai; src_b_imm = 1.
- lw: op add, imm I, mem_re = 1, reg_we = 1.
- sw: op add, imm S, mem_we = 1.
- beq/bne/blt/bge: ops 8..11, src_b_imm = 0, imm B (bit 0 = 0), is_branch = 1.
- jal: op add, src_a_pc = 1, src_b_imm = 1, imm J, reg_we = 1.
- jalr: op add, src_b_imm = 1, imm I, reg_we = 1.
- lui: op 12, src_b_imm = 1, imm = {12'b0, instr[31:12]} unshifted, because the ALU does the shift. reg_we = 1.
- All immediates except lui are sign-extended.
- rd = 0 forces reg_we = 0.
- Unsupported encodings (slt/sltu, bltu/bgeu, auipc, byte/half loads and stores, system) decode as op add with all enables 0 and ex_valid = if_valid.
- rs1/rs2 "used" flags are internal:
  - rs1 used by everything except jal and lui.
  - rs2 used by R-type, sw and branches.

Load-use hazard:
- hazard_stall = ex_valid & ex_mem_re & (ex_rd != 0) & if_valid & ((rs1_used & rs1 == ex_rd) | (rs2_used & rs2 == ex_rd)) & ~stall & ~flush.
- Asserted for exactly one cycle per load-use pair; the consumer is captured on the following edge.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- Defined: adds port ex_illegal (out, 1), registered alongside the other fields.
  - Set to 1 when if_valid and the encoding is unsupported; 0 on reset, bubble and hold-reset.
  - For illegal instructions, enables are 0 as in the base behaviour.
- Undefined: no port; unsupported encodings silently become NOPs.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU op localparams (ALU_ADD .. ALU_LUI).
  - Opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI).
  - funct3/funct7 constants.
- Sub-module id_imm_gen: combinational immediate generator, I/S/B/J/U-raw selected by opcode.
- Decode logic, hazard logic and pipeline register stay in id_ex_decode_stage.

Test Plan:
- 0x002081B3 (add x3,x1,x2), if_valid=1 -> next cycle: ex_valid=1, alu_op=0, rs1=1, rs2=2, rd=3, reg_we=1, src_b_imm=0.
- 0x40335293 (srai x5,x6,3) -> alu_op=7, imm=0x00000003, src_b_imm=1, rd=5. Then 0x402081B3 -> alu_op=1.
- 0x123453B7 (lui x7,0x12345) -> alu_op=12, imm=0x00012345, reg_we=1.
- 0xFE208CE3 (beq x1,x2,-8) -> alu_op=8, imm=0xFFFFFFF8, is_branch=1, reg_we=0.
- 0x0000A283 (lw x5,0(x1)) then 0x00028333 (add x6,x5,x0):
  - hazard_stall=1 for one cycle.
  - Next edge: ex_valid=0.
  - Following edge: add captured with alu_op=0, rd=6.
- Control priority:
  - stall=1 for 3 cycles -> outputs constant.
  - flush=1 together with stall=1 -> ex_valid=0 next edge.
  - rst mid-stream -> all outputs 0 next edge.
  - With DECODE_ILLEGAL_EN: 0x0020A1B3 (slt) -> ex_illegal=1, reg_we=0.
